// File: rtl/inst_prefetch_buffer_pkg.sv
// inst_prefetch_buffer_pkg: shared fetch types and constants.
//   NOP           - canonical RV32 no-op (addi x0, x0, 0)
//   fetch_entry_t - one queued fetch result {pc, instr}
package inst_prefetch_buffer_pkg;

    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/inst_prefetch_buffer_if.sv
// inst_prefetch_buffer_if: redirect, instruction-memory and core fetch-port signals.
//   master - prefetcher side (drives mem_req/mem_addr and the out_* handshake)
//   slave  - core and memory side
interface inst_prefetch_buffer_if;

    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    modport master (
        input  redirect_valid, redirect_pc, mem_rdata, out_ready,
        output mem_req, mem_addr, out_valid, out_pc, out_instr
    );

    modport slave (
        output redirect_valid, redirect_pc, mem_rdata, out_ready,
        input  mem_req, mem_addr, out_valid, out_pc, out_instr
    );

endinterface

// File: rtl/inst_fifo.sv
// inst_fifo: synchronous FIFO of fetch entries with flush.
//   clk, rst        - clock, asynchronous active-high reset
//   push/din        - write din at the tail
//   pop             - drop the head entry (caller guarantees non-empty)
//   flush           - empty the queue; overrides push and pop
//   count, head     - occupancy and head entry
module inst_fifo
    import inst_prefetch_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             din,
    output logic [$clog2(DEPTH):0]   count,
    output fetch_entry_t             head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign head = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

    // The credit check upstream must make a push into a full queue impossible.
    overflow_a: assert property (@(posedge clk) disable iff (rst)
        push && !flush |-> count < CW'(DEPTH));

endmodule

// File: rtl/inst_prefetch_buffer.sv
// inst_prefetch_buffer: sequential instruction prefetcher with redirect flush.
//   clk, rst   - clock, asynchronous active-high reset
//   boot_addr  - first fetch PC, held stable while rst is high
//   bus        - redirect, instruction-memory request/response and core valid/ready port
module inst_prefetch_buffer
    import inst_prefetch_buffer_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = NOP
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            boot_addr,
    inst_prefetch_buffer_if.master bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   inflight_pc;
    logic          inflight;
    logic          issue;
    logic          push;
    logic          pop;
    logic [CW-1:0] count;
    fetch_entry_t  head;
    fetch_entry_t  entry;

    // A request is only issued if its response is guaranteed a slot; pops this
    // cycle are deliberately not credited.
    assign issue = !bus.redirect_valid && (count + CW'(inflight) < CW'(DEPTH));
    assign push  = inflight && !bus.redirect_valid;
    assign pop   = bus.out_valid && bus.out_ready && !bus.redirect_valid;
    assign entry = '{pc: inflight_pc, instr: bus.mem_rdata};

    // rst gates only the output so the request path into the flops stays reset-free.
    assign bus.mem_req   = issue && !rst;
    assign bus.mem_addr  = fetch_pc;
    assign bus.out_valid = count != '0;
    assign bus.out_pc    = bus.out_valid ? head.pc : '0;
    assign bus.out_instr = bus.out_valid ? head.instr : NOP_INSTR;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= boot_addr;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (bus.redirect_valid) begin
            fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc    <= fetch_pc + 32'd4;
                inflight_pc <= fetch_pc;
            end
        end
    end

    inst_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (bus.redirect_valid),
        .din   (entry),
        .count (count),
        .head  (head)
    );

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// tb_inst_prefetch_buffer: randomized and directed checks against a queue-based fetch model.
module tb_inst_prefetch_buffer;

    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP_W = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] boot_addr = 32'h4;

    inst_prefetch_buffer_if bus ();

    inst_prefetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .boot_addr (boot_addr),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int reqs   = 0;

    // Model: words already returned and queued, the outstanding request, next PC.
    logic [31:0] q [$];
    int          fl_v;
    logic [31:0] fl_pc;
    logic [31:0] nxt;

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'h1000 + (a >> 2);
    endfunction

    // Memory answers exactly one cycle after a request; otherwise junk.
    always @(posedge clk) bus.mem_rdata <= bus.mem_req ? word(bus.mem_addr) : $urandom;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset(input logic [31:0] b);
        boot_addr = b;
        #2 rst = 1'b1;
        #1;
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_pc", bus.out_pc, 32'd0);
        check("rst_out_instr", bus.out_instr, NOP_W);
        check("rst_mem_addr", bus.mem_addr, b);
        @(posedge clk);
        #3 rst = 1'b0;
        q.delete();
        fl_v = 0;
        nxt  = b;
    endtask

    task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
        logic        e_req;
        logic        e_valid;
        bus.out_ready      = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        @(negedge clk);
        e_req   = !rv && (q.size() + fl_v < DEPTH);
        e_valid = q.size() != 0;
        check("mem_req", 32'(bus.mem_req), 32'(e_req));
        check("mem_addr", bus.mem_addr, nxt);
        check("out_valid", 32'(bus.out_valid), 32'(e_valid));
        check("out_pc", bus.out_pc, e_valid ? q[0] : 32'd0);
        check("out_instr", bus.out_instr, e_valid ? word(q[0]) : NOP_W);
        if (bus.mem_req) reqs++;
        if (rv) begin
            q.delete();
            fl_v = 0;
            nxt  = {rpc[31:2], 2'b00};
        end else begin
            if (e_valid && rdy) void'(q.pop_front());
            if (fl_v != 0) q.push_back(fl_pc);
            fl_v = e_req ? 1 : 0;
            if (e_req) begin
                fl_pc = nxt;
                nxt   = nxt + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.out_ready      = 1'b0;

        do_reset(32'h4);
        repeat (10) step(1'b1, 1'b0, 32'h0);

        do_reset(32'h4);
        reqs = 0;
        repeat (8) step(1'b0, 1'b0, 32'h0);
        check("bp_reqs", 32'(reqs), 32'(DEPTH));
        repeat (10) step(1'b1, 1'b0, 32'h0);

        do_reset(32'h4);
        repeat (4) step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h203);
        repeat (8) step(1'b1, 1'b0, 32'h0);

        step(1'b1, 1'b1, 32'h40);
        step(1'b1, 1'b1, 32'h80);
        step(1'b1, 1'b1, 32'hC0);
        repeat (6) step(1'b1, 1'b0, 32'h0);

        do_reset(32'hFFFF_FFF8);
        repeat (8) step(1'b1, 1'b0, 32'h0);

        do_reset(32'h100);
        repeat (5) step(1'b1, 1'b0, 32'h0);
        do_reset(32'h100);
        repeat (6) step(1'b1, 1'b0, 32'h0);

        for (int r = 0; r < 6; r++) begin
            do_reset($urandom & 32'hFFFF_FFFC);
            repeat (500) step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
